// File: rtl/apb_master_gen_pkg.sv
// Shared APB definitions: transfer-state encoding, select-width helper and
// a one-hot slave-select decoder.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    localparam int MAX_SLV = 16;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Out-of-range indices decode to all-zero so no slave is ever selected.
    function automatic logic [MAX_SLV-1:0] onehot_sel(input int unsigned idx,
                                                      input int unsigned n);
        logic [MAX_SLV-1:0] oh;
        oh = '0;
        if (idx < n && idx < MAX_SLV) oh = MAX_SLV'(1) << idx;
        return oh;
    endfunction

endpackage

// File: rtl/apb_master_gen_if.sv
// APB bus bundle between one master and its peripherals.
interface apb_master_gen_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int N_SLV  = 4
) ();
    logic [N_SLV-1:0]  PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic              PREADY;
    logic [DATA_W-1:0] PRDATA;
    logic              PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PREADY, PRDATA, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PREADY, PRDATA, PSLVERR
    );
endinterface

// File: rtl/apb_master_gen_wait.sv
// Saturating wait-state counter; expired_o flags the increment that reaches
// TIMEOUT. TIMEOUT=0 never expires.
module apb_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) cnt_d = '0;
        else if (en_i && cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign expired_o = (TIMEOUT != 0) && en_i && (cnt_q == CNT_MAX - 1'b1);
endmodule

// File: rtl/apb_master_gen.sv
// APB master: one command per handshake, IDLE->SETUP->ACCESS with wait states,
// PSLVERR and wait-state timeout; every output is registered.
module apb_master_gen
    import apb_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 8,
    parameter int N_SLV   = 4,
    parameter int SEL_W   = sel_width(N_SLV),
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              i_data_ready,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_data,
    input  logic [SEL_W-1:0]  i_protocol_sel,
    input  logic              i_alu_error,
    output logic              o_waiting,
    output logic              o_transfer_done,
    output logic              o_error,
    output logic [DATA_W-1:0] o_rdata,
    output apb_state_t        o_dbg_state,
    apb_master_gen_if.master  apb
);
    apb_state_t        state_q, state_d;
    logic [N_SLV-1:0]  psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              waiting_q, waiting_d;
    logic              sel_ok;
    logic              timer_clr, timer_en, timer_expired;

    assign sel_ok    = 32'(i_protocol_sel) < N_SLV;
    assign timer_clr = (state_q == SETUP);
    assign timer_en  = (state_q == ACCESS) && !apb.PREADY;

    apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk       (PCLK),
        .rst       (PRESET),
        .clr_i     (timer_clr),
        .en_i      (timer_en),
        .expired_o (timer_expired)
    );

    always_comb begin
        state_d   = state_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        rdata_d   = rdata_q;
        done_d    = 1'b0;
        error_d   = 1'b0;
        waiting_d = waiting_q;
        case (state_q)
            IDLE: begin
                psel_d    = '0;
                penable_d = 1'b0;
                waiting_d = 1'b1;
                if (i_data_ready) begin
                    // Rejected commands answer next cycle without touching the bus.
                    if (i_alu_error || !sel_ok) begin
                        done_d  = 1'b1;
                        error_d = 1'b1;
                    end else begin
                        state_d   = SETUP;
                        psel_d    = N_SLV'(onehot_sel(32'(i_protocol_sel), N_SLV));
                        pwrite_d  = i_write;
                        paddr_d   = i_addr;
                        pwdata_d  = i_write ? i_data : '0;
                        waiting_d = 1'b0;
                    end
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
                waiting_d = 1'b0;
            end
            ACCESS: begin
                // PREADY has priority over a timeout reached in the same cycle.
                if (apb.PREADY) begin
                    state_d   = IDLE;
                    psel_d    = '0;
                    penable_d = 1'b0;
                    waiting_d = 1'b1;
                    done_d    = 1'b1;
                    error_d   = apb.PSLVERR;
                    if (!pwrite_q && !apb.PSLVERR) rdata_d = apb.PRDATA;
                end else if (timer_expired) begin
                    state_d   = IDLE;
                    psel_d    = '0;
                    penable_d = 1'b0;
                    waiting_d = 1'b1;
                    done_d    = 1'b1;
                    error_d   = 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                psel_d    = '0;
                penable_d = 1'b0;
                waiting_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q   <= IDLE;
            psel_q    <= '0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            rdata_q   <= '0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            waiting_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            rdata_q   <= rdata_d;
            done_q    <= done_d;
            error_q   <= error_d;
            waiting_q <= waiting_d;
        end
    end

    assign apb.PSEL        = psel_q;
    assign apb.PENABLE     = penable_q;
    assign apb.PWRITE      = pwrite_q;
    assign apb.PADDR       = paddr_q;
    assign apb.PWDATA      = pwdata_q;
    assign o_waiting       = waiting_q;
    assign o_transfer_done = done_q;
    assign o_error         = error_q;
    assign o_rdata         = rdata_q;
    assign o_dbg_state     = state_q;
endmodule

// File: tb/tb_apb_master_gen.sv
// Bench for apb_master_gen (N_SLV=3, TIMEOUT=4): scenario tasks with inline
// cycle checks plus a scoreboard of {error, rdata} per completion.
module tb_apb_master_gen;
    import apb_pkg::*;

    localparam int DATA_W  = 8;
    localparam int ADDR_W  = 8;
    localparam int N_SLV   = 3;
    localparam int SEL_W   = 2;
    localparam int TIMEOUT = 4;
    localparam int W       = DATA_W + 1;

    logic              PCLK = 1'b0;
    logic              PRESET;
    logic              i_data_ready, i_write, i_alu_error;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_data;
    logic [SEL_W-1:0]  i_protocol_sel;
    logic              o_waiting, o_transfer_done, o_error;
    logic [DATA_W-1:0] o_rdata;
    apb_state_t        o_dbg_state;

    apb_master_gen_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_SLV(N_SLV)) bus ();

    apb_master_gen #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_SLV(N_SLV), .SEL_W(SEL_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .PCLK            (PCLK),
        .PRESET          (PRESET),
        .i_data_ready    (i_data_ready),
        .i_write         (i_write),
        .i_addr          (i_addr),
        .i_data          (i_data),
        .i_protocol_sel  (i_protocol_sel),
        .i_alu_error     (i_alu_error),
        .o_waiting       (o_waiting),
        .o_transfer_done (o_transfer_done),
        .o_error         (o_error),
        .o_rdata         (o_rdata),
        .o_dbg_state     (o_dbg_state),
        .apb             (bus)
    );

    // Clock and reset
    always #5 PCLK = ~PCLK;

    // Slave model: PREADY after slv_waits low ACCESS cycles, never when hung.
    logic [DATA_W-1:0] slv_rdata = '0;
    int                slv_waits = 0;
    logic              slv_err = 1'b0;
    logic              slv_hang = 1'b0;
    int                acc_cnt;

    always @(posedge PCLK or posedge PRESET) begin
        if (PRESET) acc_cnt <= 0;
        else        acc_cnt <= (bus.PENABLE && !bus.PREADY) ? acc_cnt + 1 : 0;
    end
    assign bus.PREADY  = bus.PENABLE && !slv_hang && (acc_cnt >= slv_waits);
    assign bus.PRDATA  = slv_rdata;
    assign bus.PSLVERR = slv_err;

    // Scoreboard
    logic [W-1:0]      exp_q[$];
    logic [W-1:0]      exp_item;
    logic [DATA_W-1:0] model_rdata = '0;
    int                n_checks = 0;
    int                n_fail = 0;
    logic [24:0]       want;

    always @(negedge PCLK) begin
        if (!PRESET && o_transfer_done) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_done: got done err=%0b rdata=%h, expected no completion",
                         o_error, o_rdata);
            end else begin
                exp_item = exp_q.pop_front();
                if ({o_error, o_rdata} !== exp_item) begin
                    n_fail++;
                    $display("FAIL sb_completion: got err=%0b rdata=%h, expected err=%0b rdata=%h",
                             o_error, o_rdata, exp_item[W-1], exp_item[DATA_W-1:0]);
                end
            end
        end
    end

    function automatic logic [24:0] pack_bus(input logic [1:0] st, input logic [2:0] sel,
                                             input logic en, input logic wr,
                                             input logic [7:0] a, input logic [7:0] d,
                                             input logic w, input logic dn);
        return {st, sel, en, wr, a, d, w, dn};
    endfunction

    function automatic logic [24:0] dut_bus();
        return {o_dbg_state, bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA,
                o_waiting, o_transfer_done};
    endfunction

    // Driver tasks
    task automatic drive_cmd(input logic wr, input logic [ADDR_W-1:0] a,
                             input logic [DATA_W-1:0] d, input logic [SEL_W-1:0] s,
                             input logic ae);
        i_data_ready   = 1'b1;
        i_write        = wr;
        i_addr         = a;
        i_data         = d;
        i_protocol_sel = s;
        i_alu_error    = ae;
    endtask

    task automatic drive_idle();
        i_data_ready   = 1'b0;
        i_alu_error    = 1'b0;
        i_write        = 1'($urandom_range(0, 1));
        i_addr         = 8'($urandom_range(0, 255));
        i_data         = 8'($urandom_range(0, 255));
        i_protocol_sel = 2'($urandom_range(0, 3));
    endtask

    // Scenarios
    task automatic test_reset();
        PRESET = 1'b1;
        drive_idle();
        repeat (3) @(negedge PCLK);
        PRESET = 1'b0;
        @(negedge PCLK);
        want = pack_bus(IDLE, 3'b000, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        n_checks++;
        if (dut_bus() !== want) begin
            n_fail++;
            $display("FAIL reset_bus: got %h, expected %h", dut_bus(), want);
        end
        n_checks++;
        if ({o_error, o_rdata} !== 9'h000) begin
            n_fail++;
            $display("FAIL reset_err_rdata: got err=%0b rdata=%h, expected 0/00", o_error, o_rdata);
        end
    endtask

    task automatic test_zero_wait_write();
        slv_waits = 0; slv_err = 1'b0; slv_hang = 1'b0;
        drive_cmd(1'b1, 8'h3C, 8'hA5, 2'd2, 1'b0);
        exp_q.push_back({1'b0, model_rdata});
        @(negedge PCLK);
        drive_idle();
        want = pack_bus(SETUP, 3'b100, 1'b0, 1'b1, 8'h3C, 8'hA5, 1'b0, 1'b0);
        n_checks++;
        if (dut_bus() !== want) begin
            n_fail++;
            $display("FAIL wr_setup: got %h, expected %h", dut_bus(), want);
        end
        @(negedge PCLK);
        want = pack_bus(ACCESS, 3'b100, 1'b1, 1'b1, 8'h3C, 8'hA5, 1'b0, 1'b0);
        n_checks++;
        if (dut_bus() !== want) begin
            n_fail++;
            $display("FAIL wr_access: got %h, expected %h", dut_bus(), want);
        end
        @(negedge PCLK);
        want = pack_bus(IDLE, 3'b000, 1'b0, 1'b1, 8'h3C, 8'hA5, 1'b1, 1'b1);
        n_checks++;
        if (dut_bus() !== want) begin
            n_fail++;
            $display("FAIL wr_done: got %h, expected %h", dut_bus(), want);
        end
        @(negedge PCLK);
    endtask

    task automatic test_wait_read();
        slv_waits = 3; slv_rdata = 8'h5A;
        drive_cmd(1'b0, 8'h81, 8'hFF, 2'd1, 1'b0);
        exp_q.push_back({1'b0, 8'h5A});
        @(negedge PCLK);
        drive_idle();
        want = pack_bus(SETUP, 3'b010, 1'b0, 1'b0, 8'h81, 8'h00, 1'b0, 1'b0);
        n_checks++;
        if (dut_bus() !== want) begin
            n_fail++;
            $display("FAIL rd_setup: got %h, expected %h", dut_bus(), want);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge PCLK);
            want = pack_bus(ACCESS, 3'b010, 1'b1, 1'b0, 8'h81, 8'h00, 1'b0, 1'b0);
            n_checks++;
            if (dut_bus() !== want) begin
                n_fail++;
                $display("FAIL rd_access_%0d: got %h, expected %h", i, dut_bus(), want);
            end
        end
        @(negedge PCLK);
        want = pack_bus(IDLE, 3'b000, 1'b0, 1'b0, 8'h81, 8'h00, 1'b1, 1'b1);
        n_checks++;
        if (dut_bus() !== want || o_rdata !== 8'h5A) begin
            n_fail++;
            $display("FAIL rd_done: got %h rdata=%h, expected %h rdata=5a", dut_bus(), o_rdata, want);
        end
        model_rdata = 8'h5A;
        slv_waits = 0;
        @(negedge PCLK);
    endtask

    task automatic test_timeout();
        slv_hang = 1'b1; slv_rdata = 8'hEE;
        drive_cmd(1'b0, 8'h44, 8'h00, 2'd0, 1'b0);
        exp_q.push_back({1'b1, model_rdata});
        @(negedge PCLK);
        drive_idle();
        for (int i = 0; i < 4; i++) begin
            @(negedge PCLK);
            want = pack_bus(ACCESS, 3'b001, 1'b1, 1'b0, 8'h44, 8'h00, 1'b0, 1'b0);
            n_checks++;
            if (dut_bus() !== want) begin
                n_fail++;
                $display("FAIL to_access_%0d: got %h, expected %h", i, dut_bus(), want);
            end
        end
        @(negedge PCLK);
        want = pack_bus(IDLE, 3'b000, 1'b0, 1'b0, 8'h44, 8'h00, 1'b1, 1'b1);
        n_checks++;
        if (dut_bus() !== want || o_error !== 1'b1 || o_rdata !== model_rdata) begin
            n_fail++;
            $display("FAIL to_abort: got %h err=%0b rdata=%h, expected %h err=1 rdata=%h",
                     dut_bus(), o_error, o_rdata, want, model_rdata);
        end
        slv_hang = 1'b0;
        @(negedge PCLK);
    endtask

    task automatic test_pslverr();
        slv_err = 1'b1; slv_rdata = 8'h99;
        drive_cmd(1'b1, 8'h55, 8'h66, 2'd0, 1'b0);
        exp_q.push_back({1'b1, model_rdata});
        @(negedge PCLK);
        drive_idle();
        repeat (2) @(negedge PCLK);
        n_checks++;
        if ({o_transfer_done, o_error} !== 2'b11) begin
            n_fail++;
            $display("FAIL slverr_wr: got done=%0b err=%0b, expected 1/1", o_transfer_done, o_error);
        end
        // Erroring read must leave o_rdata untouched.
        drive_cmd(1'b0, 8'h56, 8'h00, 2'd1, 1'b0);
        exp_q.push_back({1'b1, model_rdata});
        @(negedge PCLK);
        drive_idle();
        repeat (2) @(negedge PCLK);
        n_checks++;
        if ({o_transfer_done, o_error, o_rdata} !== {2'b11, model_rdata}) begin
            n_fail++;
            $display("FAIL slverr_rd: got done=%0b err=%0b rdata=%h, expected 1/1/%h",
                     o_transfer_done, o_error, o_rdata, model_rdata);
        end
        slv_err = 1'b0;
        @(negedge PCLK);
    endtask

    task automatic test_reject(input logic ae, input logic [SEL_W-1:0] s, input string nm);
        drive_cmd(1'b1, 8'h12, 8'h34, s, ae);
        exp_q.push_back({1'b1, model_rdata});
        @(negedge PCLK);
        drive_idle();
        n_checks++;
        if ({o_dbg_state, bus.PSEL, bus.PENABLE, o_waiting, o_transfer_done, o_error} !==
            {IDLE, 3'b000, 1'b0, 3'b111}) begin
            n_fail++;
            $display("FAIL %s: got st=%0d psel=%b en=%0b wait=%0b done=%0b err=%0b, expected 0/000/0/1/1/1",
                     nm, o_dbg_state, bus.PSEL, bus.PENABLE, o_waiting, o_transfer_done, o_error);
        end
        @(negedge PCLK);
        n_checks++;
        if ({bus.PSEL, o_transfer_done} !== 4'b0000) begin
            n_fail++;
            $display("FAIL %s_after: got psel=%b done=%0b, expected 000/0", nm, bus.PSEL, o_transfer_done);
        end
    endtask

    task automatic test_back_to_back();
        slv_waits = 0; slv_rdata = 8'h77;
        drive_cmd(1'b1, 8'h10, 8'h11, 2'd0, 1'b0);
        exp_q.push_back({1'b0, model_rdata});
        @(negedge PCLK);
        // Second command presented while busy; it must wait for the done cycle.
        drive_cmd(1'b0, 8'h20, 8'h00, 2'd1, 1'b0);
        exp_q.push_back({1'b0, 8'h77});
        want = pack_bus(SETUP, 3'b001, 1'b0, 1'b1, 8'h10, 8'h11, 1'b0, 1'b0);
        n_checks++;
        if (dut_bus() !== want) begin
            n_fail++;
            $display("FAIL b2b_setup_a: got %h, expected %h", dut_bus(), want);
        end
        @(negedge PCLK);
        @(negedge PCLK);
        want = pack_bus(IDLE, 3'b000, 1'b0, 1'b1, 8'h10, 8'h11, 1'b1, 1'b1);
        n_checks++;
        if (dut_bus() !== want) begin
            n_fail++;
            $display("FAIL b2b_done_a: got %h, expected %h", dut_bus(), want);
        end
        @(negedge PCLK);
        drive_idle();
        want = pack_bus(SETUP, 3'b010, 1'b0, 1'b0, 8'h20, 8'h00, 1'b0, 1'b0);
        n_checks++;
        if (dut_bus() !== want) begin
            n_fail++;
            $display("FAIL b2b_setup_b: got %h, expected %h", dut_bus(), want);
        end
        repeat (2) @(negedge PCLK);
        want = pack_bus(IDLE, 3'b000, 1'b0, 1'b0, 8'h20, 8'h00, 1'b1, 1'b1);
        n_checks++;
        if (dut_bus() !== want || o_rdata !== 8'h77) begin
            n_fail++;
            $display("FAIL b2b_done_b: got %h rdata=%h, expected %h rdata=77", dut_bus(), o_rdata, want);
        end
        model_rdata = 8'h77;
        @(negedge PCLK);
    endtask

    task automatic test_reset_in_access();
        logic seen_done;
        slv_hang = 1'b1;
        drive_cmd(1'b0, 8'h99, 8'h00, 2'd2, 1'b0);
        @(negedge PCLK);
        drive_idle();
        repeat (2) @(negedge PCLK);
        want = pack_bus(ACCESS, 3'b100, 1'b1, 1'b0, 8'h99, 8'h00, 1'b0, 1'b0);
        n_checks++;
        if (dut_bus() !== want) begin
            n_fail++;
            $display("FAIL rst_pre: got %h, expected %h", dut_bus(), want);
        end
        #2 PRESET = 1'b1;
        #1;
        want = pack_bus(IDLE, 3'b000, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        n_checks++;
        if (dut_bus() !== want || {o_error, o_rdata} !== 9'h000) begin
            n_fail++;
            $display("FAIL rst_async: got %h err=%0b rdata=%h, expected %h err=0 rdata=00",
                     dut_bus(), o_error, o_rdata, want);
        end
        model_rdata = '0;
        @(negedge PCLK);
        PRESET = 1'b0;
        slv_hang = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge PCLK);
            if (o_transfer_done) seen_done = 1'b1;
        end
        n_checks++;
        if (seen_done !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_no_done: got done pulse after reset, expected none");
        end
        // Recovery transfer after the dropped one.
        slv_rdata = 8'h3C;
        drive_cmd(1'b0, 8'h07, 8'h00, 2'd0, 1'b0);
        exp_q.push_back({1'b0, 8'h3C});
        @(negedge PCLK);
        drive_idle();
        repeat (2) @(negedge PCLK);
        n_checks++;
        if ({o_transfer_done, o_error, o_rdata} !== {2'b10, 8'h3C}) begin
            n_fail++;
            $display("FAIL rst_recover: got done=%0b err=%0b rdata=%h, expected 1/0/3c",
                     o_transfer_done, o_error, o_rdata);
        end
        model_rdata = 8'h3C;
        @(negedge PCLK);
    endtask

    initial begin
        test_reset();
        test_zero_wait_write();
        test_wait_read();
        test_timeout();
        test_pslverr();
        test_reject(1'b1, 2'd1, "alu_reject");
        test_reject(1'b0, 2'd3, "bad_index");
        test_back_to_back();
        test_reset_in_access();
        repeat (2) @(negedge PCLK);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d pending completions, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/apb_master_gen.md
Name: apb_master_gen

Overview:
- Parametrised APB master. Sits between the ALU/protocol-select front end and up to N_SLV APB peripherals.
- Accepts one command per handshake (read or write, address, data, target slave index) and runs a full IDLE->SETUP->ACCESS transfer.
- Supports wait states, PSLVERR and a programmable wait-state timeout.
- Returns read data and a completion/error pulse to the requester.

Parameters:
- DATA_W, 8: width of PWDATA, PRDATA, i_wdata, o_rdata.
- ADDR_W, 8: width of PADDR and i_addr.
- N_SLV, 4: number of PSEL lines (1..16).
- SEL_W, $clog2(N_SLV) (min 1): width of i_protocol_sel.
- TIMEOUT, 16: maximum ACCESS cycles without PREADY before abort. 0 disables the timeout.

Ports:
- PCLK  in  1  bus clock; all logic on rising edge.
- PRESET  in  1  reset, asynchronous, active-high.
- i_data_ready  in  1  command request; sampled only while o_waiting=1.
- i_write  in  1  1=write, 0=read.
- i_addr  in  ADDR_W  transfer address.
- i_data  in  DATA_W  write data.
- i_protocol_sel  in  SEL_W  target slave index.
- i_alu_error  in  1  upstream error flag; a request carrying it is rejected without a bus cycle.
- o_waiting  out  1  master idle and able to accept a command.
- o_transfer_done  out  1  one-cycle completion pulse.
- o_error  out  1  valid with o_transfer_done: PSLVERR, timeout, bad index, or i_alu_error.
- o_rdata  out  DATA_W  read data; valid with o_transfer_done on error-free reads; otherwise holds its previous value.
- PSEL  out  N_SLV  one-hot slave select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  ADDR_W  APB address.
- PWDATA  out  DATA_W  APB write data.
- PREADY  in  1  slave ready.
- PRDATA  in  DATA_W  slave read data.
- PSLVERR  in  1  slave error.

Behaviour:
- Reset (async, any state): state=IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, o_rdata=0, o_transfer_done=0, o_error=0, o_waiting=1, wait counter=0. A transfer in flight is dropped silently; no done pulse follows.
- All outputs are registered.
- IDLE:
  - o_waiting=1, PSEL=0, PENABLE=0; PADDR, PWDATA and PWRITE hold their last values.
  - On i_data_ready=1, the command is latched.
  - If i_alu_error=1, or i_protocol_sel>=N_SLV: no bus activity. Next cycle o_transfer_done=1 and o_error=1; state stays IDLE.
  - Otherwise go to SETUP.
- SETUP (exactly 1 cycle):
  - PSEL[idx]=1, PENABLE=0; PADDR, PWRITE and PWDATA driven from the latched command (PWDATA=0 on reads).
  - o_waiting=0; wait counter cleared.
  - Unconditional transition to ACCESS.
- ACCESS:
  - PENABLE=1; PSEL, PADDR, PWRITE and PWDATA held stable.
  - PREADY=1: the transfer ends this cycle. PRDATA is captured into o_rdata if the transfer is a read and PSLVERR=0. Next cycle: state=IDLE, o_transfer_done=1, o_error=PSLVERR, PSEL=0, PENABLE=0.
  - PREADY=0: the wait counter increments. If TIMEOUT!=0 and the counter reaches TIMEOUT, the transfer aborts: next cycle IDLE, o_transfer_done=1, o_error=1, o_rdata unchanged.
  - PREADY=1 in the same cycle the timeout is reached: PREADY wins, normal completion.
- Latency, zero-wait transfer: request seen at edge N, SETUP at N+1, ACCESS at N+2, o_transfer_done at N+3.
- Minimum spacing between accepted requests is 3 cycles (o_waiting is high only in IDLE). o_waiting rises in the same cycle as o_transfer_done, so a new request can be accepted alongside the done pulse.
- i_data_ready and command inputs are ignored while o_waiting=0.
- PSLVERR is sampled only when PENABLE=1 and PREADY=1.
- Wait counter width is $clog2(TIMEOUT+1). It saturates and never wraps.

Decomposition:
- Shared package apb_pkg holds:
  - typedef enum logic [1:0] {IDLE=0, SETUP=1, ACCESS=2} apb_state_t
  - localparam helpers for SEL_W
  - a one-hot decode function onehot_sel(idx, N)
- Sub-module apb_wait_timer: counter with clear, enable, TIMEOUT parameter and an expired output. It is reused by future APB slaves.

Test Plan:
- Zero-wait write, sel=2, addr=0x3C, data=0xA5, PREADY=1: PSEL=4'b0100 in SETUP and ACCESS; PWDATA=0xA5; done at N+3 with o_error=0.
- Read, sel=1, PRDATA=0x5A, PREADY low for 3 cycles then high: 3 extra ACCESS cycles, PADDR stable throughout; o_rdata=0x5A on done, o_error=0.
- TIMEOUT=4, PREADY held 0: abort after 4 ACCESS cycles; done with o_error=1; o_rdata keeps its previous value; PSEL returns to 0.
- Write with PSLVERR=1 and PREADY=1: done with o_error=1. Request with i_alu_error=1: done at N+1 with o_error=1 and PSEL never asserted.
- N_SLV=3 with i_protocol_sel=3: rejected, o_error=1, no PSEL. Then assert PRESET during ACCESS: all outputs 0 immediately, no done pulse, o_waiting=1.
- Back-to-back: hold i_data_ready=1 for 2 commands: second accepted in the done cycle; transfers spaced exactly 3 cycles; data and order correct.
